fetch_ctrl: RTL and testbench

// - Instruction-fetch sequencer for the SISC core. Owns the PC, drives the instruction-memory

---
 rtl/sisc_pkg.sv | 14 +
 rtl/fetch_watchdog.sv | 29 ++
 rtl/fetch_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch sequencer state encoding and default fetch geometry.
package sisc_pkg;

    localparam int unsigned SISC_ADDR_W   = 16;
    localparam int unsigned SISC_RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Ack watchdog for the fetch sequencer: counts cycles spent in FETCH and flags the
// last permitted cycle. Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Holding at zero outside FETCH makes every entry into FETCH start a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_expire = i_run && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// SISC instruction-fetch sequencer: PC, imem request/ack, IR load strobe, decode handshake.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl
    import sisc_pkg::*;
#(
    parameter int unsigned ADDR_W   = SISC_ADDR_W,
    parameter int unsigned RESET_PC = SISC_RESET_PC,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              ir_load,
    output logic              instr_valid,
    input  logic              dec_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       issue_cnt,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_issue_cnt;
    logic              w_in_fetch;
    logic              w_issue;
    logic              w_expire;

    assign w_in_fetch = (r_state == ST_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = halt ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                // An ack arriving on the expiry cycle takes priority over the watchdog.
                if (imem_ack) begin
                    w_state_nxt = ST_ISSUE;
                end else if (w_expire) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_ISSUE: begin
                if (dec_ready) begin
                    w_issue     = 1'b1;
                    w_state_nxt = halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= ADDR_W'(RESET_PC);
            r_issue_cnt <= '0;
        end else if (w_issue) begin
            r_pc        <= br_taken ? br_addr : r_pc + ADDR_W'(1);
            r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic r_fetch_err;

    fetch_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .i_run   (w_in_fetch),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_err <= 1'b0;
        end else if (w_expire && !imem_ack) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign w_expire  = 1'b0 & (|TIMEOUT);
    assign fetch_err = 1'b0;
`endif

    assign imem_req    = w_in_fetch;
    assign imem_addr   = r_pc;
    assign ir_load     = w_in_fetch && imem_ack;
    assign instr_valid = (r_state == ST_ISSUE);
    assign pc          = r_pc;
    assign issue_cnt   = r_issue_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized self-checking bench for fetch_ctrl against a transaction-level fetch model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic        ir_load;
    logic        instr_valid;
    logic        dec_ready;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        halt;
    logic [15:0] pc;
    logic [31:0] issue_cnt;
    logic        fetch_err;

    int unsigned n_chk;
    int unsigned n_fail;

    // Reference model: the address the next fetch must use, instructions issued so far,
    // and whether the watchdog error is expected to be latched.
    logic [15:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    fetch_ctrl #(
        .ADDR_W  (16),
        .RESET_PC(0),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .ir_load    (ir_load),
        .instr_valid(instr_valid),
        .dec_ready  (dec_ready),
        .br_taken   (br_taken),
        .br_addr    (br_addr),
        .halt       (halt),
        .pc         (pc),
        .issue_cnt  (issue_cnt),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic hlt);
        @(negedge clk);
        rst       = 1'b1;
        imem_ack  = 1'b0;
        dec_ready = 1'b0;
        br_taken  = 1'b0;
        halt      = 1'b0;
        #1;
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_irld",  32'(ir_load),     32'd0);
        check("rst_pc",    32'(pc),          32'd0);
        check("rst_cnt",   issue_cnt,        32'd0);
        check("rst_err",   32'(fetch_err),   32'd0);
        @(negedge clk);
        rst  = 1'b0;
        halt = hlt;
        #1;
        check("idle_req",   32'(imem_req),    32'd0);
        check("idle_valid", 32'(instr_valid), 32'd0);
        m_pc  = 16'h0000;
        m_cnt = 32'd0;
        m_err = 1'b0;
    endtask

    // One instruction: `waits` cycles without ack, then an ack cycle, then `stalls`
    // cycles of dec_ready low before the accepting cycle carrying br/halt.
    task automatic fetch_one(input int unsigned waits, input int unsigned stalls,
                             input logic br, input logic [15:0] baddr, input logic hlt);
        for (int unsigned i = 0; i <= waits; i++) begin
            @(negedge clk);
            imem_ack  = (i == waits);
            dec_ready = 1'($urandom);
            br_taken  = 1'($urandom);
            br_addr   = 16'($urandom);
            halt      = 1'($urandom);
            #1;
            check("f_req",   32'(imem_req),    32'd1);
            check("f_addr",  32'(imem_addr),   32'(m_pc));
            check("f_irld",  32'(ir_load),     32'(i == waits));
            check("f_valid", 32'(instr_valid), 32'd0);
            check("f_cnt",   issue_cnt,        m_cnt);
            check("f_err",   32'(fetch_err),   32'(m_err));
        end
        for (int unsigned j = 0; j <= stalls; j++) begin
            @(negedge clk);
            imem_ack  = 1'($urandom);
            dec_ready = (j == stalls);
            br_taken  = (j == stalls) ? br    : 1'($urandom);
            br_addr   = (j == stalls) ? baddr : 16'($urandom);
            halt      = (j == stalls) ? hlt   : 1'($urandom);
            #1;
            check("i_valid", 32'(instr_valid), 32'd1);
            check("i_req",   32'(imem_req),    32'd0);
            check("i_irld",  32'(ir_load),     32'd0);
            check("i_pc",    32'(pc),          32'(m_pc));
            check("i_cnt",   issue_cnt,        m_cnt);
        end
        m_cnt = m_cnt + 32'd1;
        m_pc  = br ? baddr : m_pc + 16'd1;
    endtask

    task automatic check_halted(input int unsigned cycles);
        for (int unsigned k = 0; k < cycles; k++) begin
            @(negedge clk);
            imem_ack  = 1'($urandom);
            dec_ready = 1'($urandom);
            br_taken  = 1'($urandom);
            br_addr   = 16'($urandom);
            halt      = 1'($urandom);
            #1;
            check("h_req",   32'(imem_req),    32'd0);
            check("h_irld",  32'(ir_load),     32'd0);
            check("h_valid", 32'(instr_valid), 32'd0);
            check("h_pc",    32'(pc),          32'(m_pc));
            check("h_cnt",   issue_cnt,        m_cnt);
            check("h_err",   32'(fetch_err),   32'(m_err));
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        imem_ack  = 1'b0;
        dec_ready = 1'b0;
        br_taken  = 1'b0;
        br_addr   = 16'h0000;
        halt      = 1'b0;
        m_pc      = 16'h0000;
        m_cnt     = 32'd0;
        m_err     = 1'b0;

        do_reset(1'b0);

        for (int unsigned n = 0; n < 4; n++) fetch_one(0, 0, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check("cnt_after4", issue_cnt, 32'd4);

        fetch_one(3, 0, 1'b0, 16'h0000, 1'b0);
        fetch_one(0, 5, 1'b1, 16'h0100, 1'b0);
        fetch_one(0, 0, 1'b0, 16'h0000, 1'b0);
        fetch_one(1, 1, 1'b1, 16'hFFFF, 1'b0);
        fetch_one(0, 0, 1'b0, 16'h0000, 1'b0);
        fetch_one(0, 0, 1'b0, 16'h0000, 1'b0);

        for (int unsigned n = 0; n < 40; n++) begin
            fetch_one($urandom_range(0, 4), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
        end

        // Asynchronous reset in the middle of a fetch must drop the request at once.
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        check("mid_req_before", 32'(imem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_req_after", 32'(imem_req), 32'd0);
        check("mid_pc",        32'(pc),       32'd0);
        check("mid_cnt",       issue_cnt,     32'd0);

        do_reset(1'b0);
        fetch_one(0, 0, 1'b0, 16'h0000, 1'b0);
        fetch_one(2, 1, 1'b0, 16'h0000, 1'b0);
        fetch_one(0, 1, 1'b1, 16'h0ABC, 1'b1);
        check_halted(5);

        do_reset(1'b1);
        check_halted(4);

`ifdef FETCH_TIMEOUT_EN
        do_reset(1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            #1;
            check("wd_req", 32'(imem_req),  32'd1);
            check("wd_err", 32'(fetch_err), 32'd0);
        end
        m_err = 1'b1;
        check_halted(3);

        do_reset(1'b0);
        fetch_one(7, 0, 1'b0, 16'h0000, 1'b1);
        check_halted(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
